multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//   Multi-cycle MIPS control FSM. Sequences the shared datapath (PC, IR, regfile, ALU, unified memory)
//   over FETCH/DECODE/EXEC/MEM/WB steps for RTYPE, ADDI, BEQ, BNE, LW, SW, J.
//   Sits between the IR opcode field and the datapath muxes/enables; ALU function decode stays in alu_control.
//   Stalls on a variable-latency memory via a ready handshake.
// PARAMETERS
//   OPCODE_W  6  opcode field width
//   STATE_W   4  state register width (encodings fixed in package)
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   opcode       in   OPCODE_W  IR[31:26], valid from DECODE onward
//   mem_ready    in   1         memory completes current read/write this cycle
//   pcWrite      out  1         unconditional PC load
//   pcWriteCond  out  1         PC load if branch condition met (datapath gates with zero/branchNe)
//   branchNe     out  1         1: condition is !zero (BNE); 0: zero (BEQ)
//   iorD         out  1         memory address: 0=PC, 1=ALUOut
//   memRead      out  1         memory read request
//   memWrite     out  1         memory write request
//   irWrite      out  1         IR load
//   memToReg     out  1         writeback data: 0=ALUOut, 1=MDR
//   regDest      out  1         write reg: 0=rt, 1=rd
//   regWrite     out  1         regfile write enable
//   aluSrcA      out  1         0=PC, 1=A
//   aluSrcB      out  2         00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   aluOp        out  2         00=add, 01=sub, 10=use funct
//   pcSource     out  2         00=ALU result, 01=ALUOut, 10=jump target
//   instr_done   out  1         one-cycle pulse in final state of each instruction
//   trap         out  1         illegal opcode (MC_ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//   - rst_n low: state=RESET async; every output 0. RESET->FETCH unconditionally next cycle.
//   - Outputs Moore-decoded from registered state, except irWrite/pcWrite in FETCH and the
//     MEM_READ/MEM_WRITE exit, which qualify on mem_ready (Mealy).
//   - FETCH: memRead=1,iorD=0,aluSrcA=0,aluSrcB=01,aluOp=00,pcSource=00. mem_ready=0: hold, no strobes.
//     mem_ready=1: irWrite=1,pcWrite=1, ->DECODE.
//   - DECODE: aluSrcA=0,aluSrcB=11,aluOp=00 (branch target into ALUOut). By opcode:
//     0x00->R_EXEC, 0x08->ADDI_EXEC, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x02->JUMP, other->see CONFIGURATION.
//   - R_EXEC: aluSrcA=1,aluSrcB=00,aluOp=10 ->R_WB. R_WB: regDest=1,regWrite=1,memToReg=0,instr_done ->FETCH.
//   - ADDI_EXEC: aluSrcA=1,aluSrcB=10,aluOp=00 ->ADDI_WB. ADDI_WB: regDest=0,regWrite=1,instr_done ->FETCH.
//   - MEM_ADDR: aluSrcA=1,aluSrcB=10,aluOp=00; LW->MEM_READ, SW->MEM_WRITE.
//   - MEM_READ: memRead=1,iorD=1; hold until mem_ready, then ->MEM_WB. MEM_WB: regDest=0,memToReg=1,
//     regWrite=1,instr_done ->FETCH.
//   - MEM_WRITE: memWrite=1,iorD=1; hold until mem_ready, then instr_done ->FETCH.
//   - BRANCH: aluSrcA=1,aluSrcB=00,aluOp=01,pcWriteCond=1,pcSource=01,branchNe=(opcode==0x05),instr_done ->FETCH.
//   - JUMP: pcWrite=1,pcSource=10,instr_done ->FETCH.
//   - Latency: R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles, plus 1 per mem_ready=0 wait cycle.
//   - Never memRead and memWrite together; regWrite never with pcWrite.
//   - Reset mid-instruction: immediate return to RESET, all strobes drop same cycle (async).
//   - mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE.
// CONFIGURATION
//   MC_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE ->TRAP; trap=1, all other outputs 0, stuck until reset.
//   Not defined: unknown opcode treated as NOP: DECODE->FETCH with instr_done=1; trap tied 0; no TRAP state.
// STRUCTURE
//   mips_pkg: opcode constants (RTYPE,ADDI,BEQ,BNE,LW,SW,JUMP), state encodings, aluOp/aluSrcB/pcSource codes.
//   Single module: state register + next-state logic + output decode; no sub-module.
// TESTING
//   1 rst_n=0 mid MEM_READ -> all outputs 0 at once; release -> RESET then FETCH, memRead=1 next cycle.
//   2 opcode=0x00, mem_ready=1 always -> FETCH,DECODE,R_EXEC,R_WB; regDest=1,regWrite=1 cycle 4; instr_done once.
//   3 opcode=0x23, mem_ready low 3 cycles in MEM_READ -> memRead,iorD held 3 extra cycles; regWrite,memToReg only in MEM_WB; total 8.
//   4 opcode=0x05 -> BRANCH: pcWriteCond=1,branchNe=1,aluOp=01; opcode=0x04 -> branchNe=0; 3 cycles each.
//   5 opcode=0x2B then 0x02 -> memWrite only in MEM_WRITE, never with memRead; JUMP pcWrite=1,pcSource=10.
//   6 opcode=0x3F: with MC_ILLEGAL_TRAP_EN trap=1 held 20 cycles until reset; without, instr_done and back to FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state encodings and datapath mux codes for the multi-cycle MIPS control.
// MC_ILLEGAL_TRAP_EN adds the S_TRAP state.
package mips_pkg;
  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_ADDI_EXEC = 4'd5,
    S_ADDI_WB   = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
`ifdef MC_ILLEGAL_TRAP_EN
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
`else
    S_JUMP      = 4'd12
`endif
  } state_e;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM sequencing the shared datapath, stalling on mem_ready.
// MC_ILLEGAL_TRAP_EN: unknown opcodes lock into S_TRAP instead of retiring as a NOP.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                branchNe,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                regDest,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          pcSource,
  output logic                instr_done,
  output logic                trap
);
  state_e state_q, state_d;
  logic   illegal;
  assign illegal = !(opcode inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JUMP});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_JUMP:       state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:       state_d = S_TRAP;
`else
          default:       state_d = S_FETCH;
`endif
        endcase
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_WB, S_ADDI_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_RESET;
    endcase
  end
  // S_RESET and any unlisted state fall through with every strobe low
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchNe    = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDest     = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_B;
    aluOp       = ALU_ADD;
    pcSource    = PCS_ALU;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_4;
        irWrite = mem_ready;
        pcWrite = mem_ready;
      end
      S_DECODE: begin
        aluSrcB = SRCB_BR;
`ifndef MC_ILLEGAL_TRAP_EN
        instr_done = illegal;
`endif
      end
      S_R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        regDest    = 1'b1;
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_ADDI_WB: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEM_WB: begin
        memToReg   = 1'b1;
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite   = 1'b1;
        iorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCS_ALUOUT;
        branchNe    = (opcode == OP_BNE);
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pcWrite    = 1'b1;
        pcSource   = PCS_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
`ifdef MC_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif
endmodule
